rx: RTL and testbench
=====================

RX -- requirements
Module: rx

Interface
REQ-001 Parameter DATA_SIZE, default 7, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, sample_tick pulses per bit period; even, >=4.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 sample_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud; all bit timing counts these pulses only.
REQ-006 data_in  input  1  asynchronous serial line; idle high.
REQ-007 ack  input  1  one-clk pulse; consumer has taken d_o.
REQ-008 d_o  output  DATA_SIZE  last correctly framed data word.
REQ-009 rx_ready  output  1  level; d_o holds an unread word.
REQ-010 overrun  output  1  sticky; a word completed while rx_ready was already 1.
REQ-011 frame_err  output  1  one-clk pulse; stop bit sampled low.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 Frame: 1 start bit (0), DATA_SIZE data bits LSB first, 1 stop bit (1); no parity.
REQ-014 data_in passes a 2-flop synchronizer (both flops reset to 1); FSM sees only the second flop (rx_s), which adds 2 clk latency.
REQ-015 States: IDLE, START, DATA, STOP, BREAK; one tick counter (0..OVERSAMPLE-1) and one bit counter (0..DATA_SIZE-1).
REQ-016 Counters, shifts and state changes occur only in cycles with sample_tick=1, except ack handling (REQ-023).
REQ-017 IDLE: on tick with rx_s=0 -> START, tick counter=0.
REQ-018 START: on tick, if counter=OVERSAMPLE/2-1: rx_s=0 -> DATA (counters=0); rx_s=1 -> IDLE (false start, no output change); otherwise counter+1.
REQ-019 DATA: on tick, if counter=OVERSAMPLE-1: shift rx_s into shift register MSB (right shift), counter=0; after bit DATA_SIZE-1 -> STOP, else bit counter+1; otherwise counter+1.
REQ-020 Sampling is therefore mid-bit: data bit n sampled OVERSAMPLE/2 + (n+1)*OVERSAMPLE ticks after the start edge was detected.
REQ-021 STOP: on tick with counter=OVERSAMPLE-1: rx_s=1 -> d_o<=shift register, rx_ready<=1, -> IDLE; rx_s=0 -> frame_err=1 for that clk, d_o and rx_ready unchanged, -> BREAK.
REQ-022 BREAK: stay until tick with rx_s=1, then -> IDLE; prevents a low line re-triggering start.
REQ-023 ack=1 clears rx_ready and overrun next clk.
REQ-024 Good-stop completion with rx_ready=1 and ack=0: d_o overwritten, rx_ready stays 1, overrun<=1.
REQ-025 Completion and ack in same clk: completion wins; rx_ready=1, d_o=new word, overrun not set and cleared.
REQ-026 ack while rx_ready=0: no effect (overrun still cleared).
REQ-027 Ticks are never missed by state changes; sample_tick held high every clk is legal.

Reset
REQ-028 reset=0 at a rising edge: state=IDLE, counters=0, shift register=0, synchronizer flops=1.
REQ-029 Output reset values: d_o=0, rx_ready=0, overrun=0, frame_err=0, busy=0.
REQ-030 reset asserted mid-frame aborts the frame silently; no rx_ready, no frame_err; next start edge after release is received normally.

Verification (DATA_SIZE=7, OVERSAMPLE=16, sample_tick 1 clk in 4)
REQ-031 Send 7'b1010111, 1 stop, line idle high -> d_o=7'h57, rx_ready=1 after stop mid-sample, busy=0, frame_err=0, overrun=0.
REQ-032 Line low 3 ticks then high -> START aborts to IDLE, no rx_ready, busy back to 0, d_o unchanged.
REQ-033 Send 7'h2A with stop=0, line held low 40 ticks then high -> one frame_err pulse, rx_ready=0, busy=1 until line high, then 7'h11 received correctly.
REQ-034 Send 7'h01 then 7'h7F without ack -> d_o=7'h7F, rx_ready=1, overrun=1; ack -> both 0 next clk.
REQ-035 ack coincident with second completion -> rx_ready=1, d_o=second word, overrun=0.
REQ-036 reset=0 for one clk mid-data of 7'h55 -> all outputs at reset values; following 7'h33 -> d_o=7'h33, rx_ready=1.

Source files
------------

// File: rtl/rx.sv
// RX: oversampled serial receiver with a 2-flop input synchronizer.
// Frame: start bit, DATA_SIZE data bits LSB first, one stop bit, no parity.
module rx #(
    parameter int DATA_SIZE  = 7,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 data_in,
    input  logic                 ack,
    output logic [DATA_SIZE-1:0] d_o,
    output logic                 rx_ready,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_END = BW'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_SIZE-1:0] sh_q, sh_d;
    logic                 sync1, rx_s;
    logic                 done, fe_d;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done    = 1'b0;
        fe_d    = 1'b0;
        if (sample_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == T_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == T_END) begin
                        tick_d = '0;
                        sh_d   = {rx_s, sh_q[DATA_SIZE-1:1]};
                        if (bit_q == B_END) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == T_END) begin
                        tick_d = '0;
                        if (rx_s) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                // hold off until the line returns high so a break is not a start
                BREAK: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            d_o       <= '0;
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= data_in;
            rx_s      <= sync1;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            frame_err <= fe_d;
            // a completing word takes priority over a same-cycle ack
            if (done) begin
                d_o      <= sh_q;
                rx_ready <= 1'b1;
            end else if (ack) begin
                rx_ready <= 1'b0;
            end
            if (done && rx_ready && !ack) overrun <= 1'b1;
            else if (ack) overrun <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rx.sv
// Bench for rx: random and directed frames checked against a
// transaction-level model of the received word and status flags.
module tb_rx;
    localparam int DS = 7;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_tick;
    logic          data_in;
    logic          ack;
    logic [DS-1:0] d_o;
    logic          rx_ready;
    logic          overrun;
    logic          frame_err;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;
    int phase = 0;
    logic last_tick = 1'b0;
    int fe_seen = 0;

    logic [DS-1:0] m_d;
    logic          m_rdy;
    logic          m_ovr;
    int            m_fe;

    rx #(.DATA_SIZE(DS), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .data_in    (data_in),
        .ack        (ack),
        .d_o        (d_o),
        .rx_ready   (rx_ready),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock; tick is asserted on every 4th edge
    task automatic cyc1(input logic a);
        sample_tick = (phase == 3);
        ack = a;
        @(posedge clk);
        #1;
        last_tick = sample_tick;
        phase = (phase + 1) % 4;
        ack = 1'b0;
    endtask

    // run until n ticks have passed; ack rides on tick number ack_at
    task automatic hold(input int n, input int ack_at);
        int t = 0;
        while (t < n) begin
            cyc1(ack_at == t + 1 && phase == 3);
            if (last_tick) t++;
        end
    endtask

    task automatic send_frame(input logic [DS-1:0] w, input logic stop,
                              input int ack_at);
        data_in = 1'b0;
        hold(OS, 0);
        for (int i = 0; i < DS; i++) begin
            data_in = w[i];
            hold(OS, 0);
        end
        check("busy_mid", busy, 1);
        data_in = stop;
        hold(OS, ack_at);
    endtask

    task automatic good(input logic [DS-1:0] w, input logic ackc);
        if (m_rdy && !ackc) m_ovr = 1'b1;
        else if (ackc) m_ovr = 1'b0;
        m_rdy = 1'b1;
        m_d = w;
    endtask

    task automatic check_all(input string tag, input logic exp_busy);
        check({tag, "_d_o"}, d_o, m_d);
        check({tag, "_rdy"}, rx_ready, m_rdy);
        check({tag, "_ovr"}, overrun, m_ovr);
        check({tag, "_fe"}, fe_seen, m_fe);
        check({tag, "_busy"}, busy, exp_busy);
    endtask

    task automatic do_ack();
        cyc1(1'b1);
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        check("ack_rdy", rx_ready, m_rdy);
        check("ack_ovr", overrun, m_ovr);
        hold(1, 0);
    endtask

    // completion lands on the 9th tick of the stop bit
    localparam int ACK_AT_DONE = OS / 2 + 1;

    initial begin
        logic [DS-1:0] w;
        int kind;
        reset = 1'b0;
        data_in = 1'b1;
        ack = 1'b0;
        sample_tick = 1'b0;
        m_d = '0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        m_fe = 0;
        repeat (6) cyc1(1'b0);
        check_all("reset", 1'b0);
        reset = 1'b1;
        hold(4, 0);

        w = 7'b1010111;
        send_frame(w, 1'b1, 0);
        good(w, 1'b0);
        check_all("basic", 1'b0);
        check("basic_val", d_o, 32'h57);

        data_in = 1'b0;
        hold(3, 0);
        check("fs_busy", busy, 1);
        data_in = 1'b1;
        hold(16, 0);
        check_all("false_start", 1'b0);

        do_ack();
        send_frame(7'h2A, 1'b0, 0);
        m_fe++;
        hold(40 - OS, 0);
        check_all("break", 1'b1);
        data_in = 1'b1;
        hold(2, 0);
        check("break_idle", busy, 0);
        send_frame(7'h11, 1'b1, 0);
        good(7'h11, 1'b0);
        check_all("after_break", 1'b0);

        do_ack();
        send_frame(7'h01, 1'b1, 0);
        good(7'h01, 1'b0);
        send_frame(7'h7F, 1'b1, 0);
        good(7'h7F, 1'b0);
        check_all("overrun", 1'b0);
        do_ack();

        send_frame(7'h0F, 1'b1, 0);
        good(7'h0F, 1'b0);
        send_frame(7'h22, 1'b1, 0);
        good(7'h22, 1'b0);
        send_frame(7'h44, 1'b1, ACK_AT_DONE);
        good(7'h44, 1'b1);
        check_all("ack_coinc", 1'b0);

        w = 7'h55;
        data_in = 1'b0;
        hold(OS, 0);
        for (int i = 0; i < 3; i++) begin
            data_in = w[i];
            hold(OS, 0);
        end
        reset = 1'b0;
        cyc1(1'b0);
        reset = 1'b1;
        data_in = 1'b1;
        m_d = '0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        check_all("reset_mid", 1'b0);
        hold(20, 0);
        check_all("reset_idle", 1'b0);
        send_frame(7'h33, 1'b1, 0);
        good(7'h33, 1'b0);
        check_all("after_reset", 1'b0);

        for (int n = 0; n < 20; n++) begin
            w = DS'($urandom_range(0, (1 << DS) - 1));
            kind = $urandom_range(0, 9);
            hold($urandom_range(0, 5), 0);
            if (kind == 0) begin
                send_frame(w, 1'b0, 0);
                m_fe++;
                hold($urandom_range(0, 30), 0);
                check_all("rnd_break", 1'b1);
                data_in = 1'b1;
                hold(2, 0);
                check_all("rnd_brk_end", 1'b0);
            end else if (kind <= 2) begin
                send_frame(w, 1'b1, ACK_AT_DONE);
                good(w, 1'b1);
                check_all("rnd_coinc", 1'b0);
            end else begin
                if (kind <= 4) do_ack();
                send_frame(w, 1'b1, 0);
                good(w, 1'b0);
                check_all("rnd_frame", 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
